// File: rtl/matrix_stack_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : matrix_stack_ctrl
//  Purpose  : NUM_STACKS independent GL matrix stacks (modelview, projection,
//             texture, ...), each DEPTH matrices of ROWS rows. Supports push
//             (copy top up one level), pop, row-streamed load, load-identity
//             and whole-matrix write-back from the multiply unit. Every stack
//             self-initialises level 0 to identity after reset.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             stack_sel        - target stack for commands and peek/level view
//             cmd_valid/cmd_op - command handshake (accepted when cmd_ready)
//             cmd_ready, busy  - ready only in IDLE; busy is its complement
//             data_in/valid    - LOAD row stream, row 0 first
//             write_in         - WRITE payload, row 0 in the MSBs
//             peek_out         - top matrix of stack_sel (combinational)
//             level_out        - current level of stack_sel
//             overflow         - one-cycle pulse on rejected PUSH
//             underflow        - one-cycle pulse on rejected POP
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_stack_ctrl #(
    parameter  int ROWS       = 4,
    parameter  int DEPTH      = 8,
    parameter  int NUM_STACKS = 2,
    localparam int ROW_W      = 32 * ROWS,
    localparam int MAT_W      = ROWS * ROW_W,
    localparam int LVL_W      = $clog2(DEPTH),
    localparam int SEL_W      = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   stack_sel,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    output logic               cmd_ready,
    input  logic [ROW_W-1:0]   data_in,
    input  logic               data_valid,
    input  logic [MAT_W-1:0]   write_in,
    output logic [MAT_W-1:0]   peek_out,
    output logic [LVL_W-1:0]   level_out,
    output logic               overflow,
    output logic               underflow,
    output logic               busy
);

    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_LOAD_ID = 3'd4;
    localparam logic [2:0] OP_WRITE   = 3'd5;

    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH - 1);
    localparam logic [RC_W-1:0]  ROW_LAST = RC_W'(ROWS - 1);
    localparam logic [SEL_W-1:0] STK_LAST = SEL_W'(NUM_STACKS - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_COPY = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    // Identity row r: 1.0f in element r, element 0 sits in the row MSBs.
    function automatic logic [ROW_W-1:0] ident_row(input int r);
        logic [ROW_W-1:0] res;
        res = '0;
        res[(ROWS - r) * 32 - 1 -: 32] = 32'h3F80_0000;
        return res;
    endfunction

    // Storage and state
    logic [ROW_W-1:0] stack_mem_q [NUM_STACKS][DEPTH][ROWS];

    state_t           state_q,     state_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic [RC_W-1:0]  cnt_q,       cnt_d;
    logic [SEL_W-1:0] init_q,      init_d;
    logic [LVL_W-1:0] level_q [NUM_STACKS];
    logic [LVL_W-1:0] level_d [NUM_STACKS];
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    // Single write port covering one matrix: any subset of its rows per cycle
    logic [SEL_W-1:0]           wr_stack;
    logic [LVL_W-1:0]           wr_level;
    logic [ROWS-1:0]            wr_en;
    logic [ROWS-1:0][ROW_W-1:0] wr_data;

    // Out-of-range selects (non power-of-two NUM_STACKS) are treated as NOP
    // and read back as stack 0.
    logic             sel_ok;
    logic [SEL_W-1:0] sel_idx;
    logic [LVL_W-1:0] sel_lvl;

    assign sel_ok  = (int'(stack_sel) < NUM_STACKS);
    assign sel_idx = sel_ok ? stack_sel : '0;
    assign sel_lvl = level_q[sel_idx];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        init_d      = init_q;
        level_d     = level_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_stack    = sel_q;
        wr_level    = level_q[sel_q];
        wr_en       = '0;
        wr_data     = '0;

        case (state_q)
            ST_INIT: begin
                // One stack per cycle: identity into level 0
                wr_stack = init_q;
                wr_level = '0;
                wr_en    = '1;
                for (int r = 0; r < ROWS; r++) begin
                    wr_data[r] = ident_row(r);
                end
                if (init_q == STK_LAST) begin
                    init_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    init_d = init_q + SEL_W'(1);
                end
            end

            ST_IDLE: begin
                if (cmd_valid && sel_ok) begin
                    wr_stack = stack_sel;
                    wr_level = sel_lvl;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (sel_lvl == LVL_MAX) begin
                                overflow_d = 1'b1;
                            end else begin
                                sel_d   = stack_sel;
                                cnt_d   = '0;
                                state_d = ST_COPY;
                            end
                        end
                        OP_POP: begin
                            if (sel_lvl == '0) begin
                                underflow_d = 1'b1;
                            end else begin
                                level_d[sel_idx] = sel_lvl - LVL_W'(1);
                            end
                        end
                        OP_LOAD: begin
                            sel_d   = stack_sel;
                            cnt_d   = '0;
                            state_d = ST_LOAD;
                        end
                        OP_LOAD_ID: begin
                            wr_en = '1;
                            for (int r = 0; r < ROWS; r++) begin
                                wr_data[r] = ident_row(r);
                            end
                        end
                        OP_WRITE: begin
                            wr_en = '1;
                            for (int r = 0; r < ROWS; r++) begin
                                wr_data[r] = write_in[(ROWS - r) * ROW_W - 1 -: ROW_W];
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_COPY: begin
                // Copy one row of the top into the slot above it; the level
                // only moves once the whole matrix has been duplicated.
                wr_level       = level_q[sel_q] + LVL_W'(1);
                wr_en[cnt_q]   = 1'b1;
                wr_data[cnt_q] = stack_mem_q[sel_q][level_q[sel_q]][cnt_q];
                if (cnt_q == ROW_LAST) begin
                    level_d[sel_q] = level_q[sel_q] + LVL_W'(1);
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + RC_W'(1);
                end
            end

            ST_LOAD: begin
                if (data_valid) begin
                    wr_en[cnt_q]   = 1'b1;
                    wr_data[cnt_q] = data_in;
                    if (cnt_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + RC_W'(1);
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sel_q       <= '0;
            cnt_q       <= '0;
            init_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int s = 0; s < NUM_STACKS; s++) begin
                level_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            init_q      <= init_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            level_q     <= level_d;
        end
    end

    // Matrix storage carries no reset; INIT rebuilds level 0 of every stack
    // and higher levels are always rewritten by a PUSH before becoming top.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                if (wr_en[r]) begin
                    stack_mem_q[wr_stack][wr_level][r] <= wr_data[r];
                end
            end
        end
    end

    always_comb begin
        peek_out = '0;
        for (int r = 0; r < ROWS; r++) begin
            peek_out[(ROWS - r) * ROW_W - 1 -: ROW_W] = stack_mem_q[sel_idx][sel_lvl][r];
        end
    end

    assign level_out = sel_lvl;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
